// File: rtl/mode_seq_pkg.sv
// mode_seq_pkg: shared state encoding and time-field limits for the front-panel time-setting sequencer.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

endpackage

// File: rtl/interval_timer.sv
// interval_timer: free-running period counter with one-cycle done pulse; restarts on clr or on done.
module interval_timer #(
    parameter int unsigned PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned W = $clog2(PERIOD);

    logic [W-1:0] cnt_q;

    assign done = en && !clr && (cnt_q == W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr || done)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: RUN -> edit hours -> edit minutes -> commit controller with shadow time and blink.
// Idle-edit abandonment is built only when MODE_SEQ_TIMEOUT_EN is defined.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_T = 20000,
    parameter int unsigned BLINK_T   = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              short_p,
    input  logic              long_p,
    input  logic [HOUR_W-1:0] cur_h,
    input  logic [MIN_W-1:0]  cur_m,
    output logic [1:0]        mode,
    output logic [HOUR_W-1:0] set_h,
    output logic [MIN_W-1:0]  set_m,
    output logic              load,
    output logic              blink,
    output logic              timed_out
);

    if (TIMEOUT_T < 2 || BLINK_T < 2) begin : g_param_chk
        $error("mode_sequencer: TIMEOUT_T and BLINK_T must be >= 2");
    end

    state_e            state_q;
    logic [HOUR_W-1:0] set_h_q, set_h_d;
    logic [MIN_W-1:0]  set_m_q, set_m_d;
    logic              load_q, blink_q, timed_out_q;
    logic              edit, ev, blink_done, to_done;

    assign edit    = (state_q == EDIT_H) || (state_q == EDIT_M);
    assign ev      = short_p || long_p;
    assign set_h_d = (set_h_q == HOUR_MAX) ? '0 : set_h_q + 1'b1;
    assign set_m_d = (set_m_q == MIN_MAX) ? '0 : set_m_q + 1'b1;

    // Both timers sit at zero outside edit states and restart on any press.
    interval_timer #(.PERIOD(BLINK_T)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (!edit || ev),
        .en   (edit),
        .done (blink_done)
    );

`ifdef MODE_SEQ_TIMEOUT_EN
    interval_timer #(.PERIOD(TIMEOUT_T)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (!edit || ev),
        .en   (edit),
        .done (to_done)
    );
`else
    assign to_done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            set_h_q     <= '0;
            set_m_q     <= '0;
            load_q      <= 1'b0;
            blink_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            timed_out_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (long_p) begin
                        state_q <= EDIT_H;
                        set_h_q <= cur_h;
                        set_m_q <= cur_m;
                        blink_q <= 1'b1;
                    end
                end
                EDIT_H, EDIT_M: begin
                    if (long_p) begin
                        state_q <= (state_q == EDIT_H) ? EDIT_M : COMMIT;
                        load_q  <= (state_q == EDIT_M);
                        blink_q <= (state_q == EDIT_H);
                    end else if (to_done) begin
                        state_q     <= RUN;
                        timed_out_q <= 1'b1;
                        blink_q     <= 1'b0;
                    end else if (short_p) begin
                        if (state_q == EDIT_H)
                            set_h_q <= set_h_d;
                        else
                            set_m_q <= set_m_d;
                        blink_q <= 1'b1;
                    end else if (blink_done) begin
                        blink_q <= ~blink_q;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign mode      = state_q;
    assign set_h     = set_h_q;
    assign set_m     = set_m_q;
    assign load      = load_q;
    assign blink     = blink_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: vector table, corner sequences and randomized run against a behavioural model.
module tb_mode_sequencer;

    localparam int TO_T = 50;
    localparam int BL_T = 4;
`ifdef MODE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       short_p = 1'b0, long_p = 1'b0;
    logic [4:0] cur_h = '0;
    logic [5:0] cur_m = '0;
    logic [1:0] mode;
    logic [4:0] set_h;
    logic [5:0] set_m;
    logic       load, blink, timed_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.TIMEOUT_T(TO_T), .BLINK_T(BL_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .short_p   (short_p),
        .long_p    (long_p),
        .cur_h     (cur_h),
        .cur_m     (cur_m),
        .mode      (mode),
        .set_h     (set_h),
        .set_m     (set_m),
        .load      (load),
        .blink     (blink),
        .timed_out (timed_out)
    );

    typedef struct {
        bit s, l;
        int ch, cm;
        int md, h, m;
        bit ld, bl;
    } vec_t;

    vec_t vt[$];

    int m_mode, m_h, m_m, m_age, m_idle;
    bit m_load, m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic l);
        @(negedge clk);
        short_p = s;
        long_p  = l;
        @(posedge clk);
        #1;
        short_p = 1'b0;
        long_p  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        short_p = 1'b0;
        long_p  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_h = 0; m_m = 0; m_age = 0; m_idle = 0; m_load = 0; m_to = 0;
    endtask

    // Reference: edit progress tracked as counts of quiet cycles since the last restart.
    function automatic void model_step(bit s, bit l, int ch, int cm);
        m_load = 0;
        m_to   = 0;
        if (m_mode == 0) begin
            if (l) begin
                m_mode = 1; m_h = ch; m_m = cm; m_age = 0; m_idle = 0;
            end
        end else if (m_mode == 3) begin
            m_mode = 0;
        end else if (l) begin
            m_mode = m_mode + 1;
            m_load = (m_mode == 3);
            m_age = 0; m_idle = 0;
        end else if (s) begin
            if (m_mode == 1) m_h = (m_h + 1) % 24;
            else             m_m = (m_m + 1) % 60;
            m_age = 0; m_idle = 0;
        end else begin
            m_age++;
            m_idle++;
            if (TO_EN && m_idle == TO_T) begin
                m_mode = 0;
                m_to = 1;
            end
        end
    endfunction

    function automatic bit model_blink();
        return (m_mode == 1 || m_mode == 2) && ((m_age / BL_T) % 2 == 0);
    endfunction

    initial begin
        int n, saw_to, saw_load, burst;
        #2;
        chk("reset mode", mode, 0);
        chk("reset set_h", set_h, 0);
        chk("reset set_m", set_m, 0);
        chk("reset load", load, 0);
        chk("reset blink", blink, 0);
        chk("reset timed_out", timed_out, 0);
        do_reset();

        vt.push_back('{0, 1, 10, 30, 1, 10, 30, 0, 1});
        vt.push_back('{1, 0,  0,  0, 1, 11, 30, 0, 1});
        vt.push_back('{1, 0,  0,  0, 1, 12, 30, 0, 1});
        vt.push_back('{1, 0,  0,  0, 1, 13, 30, 0, 1});
        vt.push_back('{0, 1,  0,  0, 2, 13, 30, 0, 1});
        vt.push_back('{1, 0,  0,  0, 2, 13, 31, 0, 1});
        vt.push_back('{1, 0,  0,  0, 2, 13, 32, 0, 1});
        vt.push_back('{0, 1,  0,  0, 3, 13, 32, 1, 0});
        vt.push_back('{1, 1,  0,  0, 0, 13, 32, 0, 0});
        vt.push_back('{1, 0,  4,  4, 0, 13, 32, 0, 0});
        vt.push_back('{0, 1, 23, 59, 1, 23, 59, 0, 1});
        vt.push_back('{1, 0,  0,  0, 1,  0, 59, 0, 1});
        vt.push_back('{0, 1,  0,  0, 2,  0, 59, 0, 1});
        vt.push_back('{1, 0,  0,  0, 2,  0,  0, 0, 1});
        vt.push_back('{1, 1,  0,  0, 3,  0,  0, 1, 0});
        vt.push_back('{0, 0,  0,  0, 0,  0,  0, 0, 0});
        vt.push_back('{0, 1,  5,  7, 1,  5,  7, 0, 1});
        vt.push_back('{1, 1,  0,  0, 2,  5,  7, 0, 1});
        vt.push_back('{0, 1,  0,  0, 3,  5,  7, 1, 0});
        vt.push_back('{0, 0,  0,  0, 0,  5,  7, 0, 0});
        foreach (vt[i]) begin
            cur_h = 5'(vt[i].ch);
            cur_m = 6'(vt[i].cm);
            tick(vt[i].s, vt[i].l);
            chk($sformatf("vec%0d mode", i), mode, vt[i].md);
            chk($sformatf("vec%0d set_h", i), set_h, vt[i].h);
            chk($sformatf("vec%0d set_m", i), set_m, vt[i].m);
            chk($sformatf("vec%0d load", i), load, vt[i].ld);
            chk($sformatf("vec%0d blink", i), blink, vt[i].bl);
            chk($sformatf("vec%0d timed_out", i), timed_out, 0);
        end

        // Blink cadence and restart from the low phase.
        do_reset();
        cur_h = 5'd1; cur_m = 6'd2;
        tick(0, 1);
        chk("blink entry", blink, 1);
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0);
            chk($sformatf("blink q%0d", k), blink, (k / BL_T) % 2 == 0);
        end
        tick(1, 0);
        chk("blink short", blink, 1);
        chk("blink short set_h", set_h, 2);
        for (int j = 1; j <= 7; j++) begin
            tick(0, 0);
            chk($sformatf("blink r%0d", j), blink, j < BL_T);
        end

        // Idle edit: abandoned after TO_T cycles only when the timeout is built in.
        do_reset();
        cur_h = 5'd9; cur_m = 6'd15;
        tick(0, 1);
        chk("timeout entry mode", mode, 1);
        n = 1; saw_to = 0; saw_load = 0;
        for (int i = 0; i < 120; i++) begin
            tick(0, 0);
            if (load) saw_load++;
            if (timed_out) saw_to++;
            if (mode == 2'd1) n++;
            else break;
        end
        chk("timeout cycles in edit", n, TO_EN ? TO_T : 121);
        chk("timeout pulse count", saw_to, TO_EN ? 1 : 0);
        chk("timeout no load", saw_load, 0);
        tick(0, 0);
        chk("timeout pulse width", timed_out, 0);
        chk("timeout final mode", mode, TO_EN ? 0 : 1);
        chk("timeout keeps set_h", set_h, 9);
        chk("timeout keeps set_m", set_m, 15);

        // Asynchronous reset mid-edit.
        do_reset();
        cur_h = 5'd10; cur_m = 6'd20;
        tick(0, 1);
        tick(0, 1);
        tick(1, 0);
        chk("pre-reset mode", mode, 2);
        chk("pre-reset set_m", set_m, 21);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async mode", mode, 0);
        chk("async set_h", set_h, 0);
        chk("async set_m", set_m, 0);
        chk("async load", load, 0);
        chk("async blink", blink, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit s, l;
            r = $urandom_range(0, 99);
            s = 0; l = 0;
            if (burst > 0) burst--;
            else if (r < 12) s = 1;
            else if (r < 18) l = 1;
            else if (r < 20) begin s = 1; l = 1; end
            else if (r == 20) burst = 60;
            cur_h = 5'($urandom_range(0, 23));
            cur_m = 6'($urandom_range(0, 59));
            model_step(s, l, int'(cur_h), int'(cur_m));
            tick(s, l);
            chk("rand mode", mode, m_mode);
            chk("rand set_h", set_h, m_h);
            chk("rand set_m", set_m, m_m);
            chk("rand load", load, m_load);
            chk("rand blink", blink, model_blink());
            chk("rand timed_out", timed_out, m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
